// File: rtl/elevator_request_scheduler_if.sv
// Bus between the elevator request scheduler and its environment:
// call buttons, the one-second timer, the floor FSM and status readers.
interface elevator_request_scheduler_if #(
  parameter int N_FLOORS = 4
);
  logic                tick;
  logic [N_FLOORS-1:0] call_req;
  logic [N_FLOORS-1:0] present_floor;
  logic [N_FLOORS-1:0] target_floor;
  logic                door_open;
  logic                dir_up;
  logic                dir_down;
  logic [N_FLOORS-1:0] pending;
  logic                busy;

  modport master (
    output tick, call_req, present_floor,
    input  target_floor, door_open, dir_up, dir_down, pending, busy
  );

  modport slave (
    input  tick, call_req, present_floor,
    output target_floor, door_open, dir_up, dir_down, pending, busy
  );
endinterface

// File: rtl/elevator_request_scheduler.sv
// SCAN-ordered elevator request scheduler: latches floor calls into a
// pending bitmap, picks a one-hot target floor for the floor FSM and
// times the door dwell in one-second ticks.
module elevator_request_scheduler #(
  parameter int N_FLOORS    = 4,
  parameter int DWELL_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  elevator_request_scheduler_if.slave bus
);

  localparam int DW = $clog2(DWELL_TICKS + 1);

  typedef logic [N_FLOORS-1:0] floor_t;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t          state, state_next;
  floor_t          pending, pending_next;
  floor_t          target, target_next;
  logic [DW-1:0]   dwell, dwell_next;
  logic            last_up, last_up_next;
  logic            door_open_r, dir_up_r, dir_down_r;

  floor_t          pos;
  logic            pos_valid;
  floor_t          above, below, here;
  floor_t          up_pick, down_pick;
  floor_t          req, clr;

  // Isolates the lowest set bit (nearest floor above the car).
  function automatic floor_t lowest_bit(input floor_t v);
    floor_t neg;
    neg = ~v + floor_t'(1);
    return v & neg;
  endfunction

  // Isolates the highest set bit (nearest floor below the car).
  function automatic floor_t highest_bit(input floor_t v);
    floor_t r;
    r = '0;
    for (int i = 0; i < N_FLOORS; i++)
      if (v[i]) r = floor_t'(1) << i;
    return r;
  endfunction

  function automatic logic is_onehot(input floor_t v);
    return (v != '0) && ((v & (v - floor_t'(1))) == '0);
  endfunction

  // Split the pending calls around the car position reported by the floor FSM.
  always_comb begin
    floor_t pos_shl;
    pos       = bus.present_floor;
    pos_valid = is_onehot(pos);
    pos_shl   = pos << 1;
    above     = pending & ~(pos_shl - floor_t'(1));
    below     = pending & (pos - floor_t'(1));
    here      = pending & pos;
    up_pick   = lowest_bit(above);
    down_pick = highest_bit(below);
  end

  // Next-state, target, dwell and pending-bitmap decisions.
  always_comb begin
    state_next   = state;
    target_next  = target;
    dwell_next   = dwell;
    last_up_next = last_up;
    req          = bus.call_req;
    clr          = '0;

    // An invalid car position freezes every decision; calls are still latched.
    if (pos_valid) begin
      if (state == DOOR_OPEN) req = bus.call_req & ~pos;

      case (state)
        IDLE: begin
          if (here != '0) begin
            state_next  = DOOR_OPEN;
            target_next = pos;
          end else if (above != '0) begin
            state_next  = MOVE_UP;
            target_next = up_pick;
          end else if (below != '0) begin
            state_next  = MOVE_DOWN;
            target_next = down_pick;
          end else begin
            target_next = pos;
          end
        end

        MOVE_UP: begin
          if (here != '0) begin
            state_next   = DOOR_OPEN;
            target_next  = pos;
            last_up_next = 1'b1;
          end else if (above != '0) begin
            target_next = up_pick;
          end else begin
            state_next  = IDLE;
            target_next = pos;
          end
        end

        MOVE_DOWN: begin
          if (here != '0) begin
            state_next   = DOOR_OPEN;
            target_next  = pos;
            last_up_next = 1'b0;
          end else if (below != '0) begin
            target_next = down_pick;
          end else begin
            state_next  = IDLE;
            target_next = pos;
          end
        end

        DOOR_OPEN: begin
          target_next = pos;
          // A fresh call at this floor keeps the door open for a full dwell.
          if ((bus.call_req & pos) != '0) begin
            dwell_next = '0;
          end else if (bus.tick) begin
            if (dwell == DW'(DWELL_TICKS - 1)) begin
              dwell_next = '0;
              if (last_up && (above != '0)) begin
                state_next  = MOVE_UP;
                target_next = up_pick;
              end else if (below != '0) begin
                state_next  = MOVE_DOWN;
                target_next = down_pick;
              end else if (above != '0) begin
                state_next  = MOVE_UP;
                target_next = up_pick;
              end else begin
                state_next = IDLE;
              end
            end else begin
              dwell_next = dwell + DW'(1);
            end
          end
        end

        default: state_next = IDLE;
      endcase

      // Arrival serves the call at this floor.
      if ((state_next == DOOR_OPEN) && (state != DOOR_OPEN)) clr = pos;
    end

    pending_next = (pending | req) & ~clr;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      target      <= floor_t'(1);
      dwell       <= '0;
      last_up     <= 1'b1;
      door_open_r <= 1'b0;
      dir_up_r    <= 1'b0;
      dir_down_r  <= 1'b0;
    end else begin
      state       <= state_next;
      pending     <= pending_next;
      target      <= target_next;
      dwell       <= dwell_next;
      last_up     <= last_up_next;
      door_open_r <= (state_next == DOOR_OPEN);
      dir_up_r    <= (state_next == MOVE_UP);
      dir_down_r  <= (state_next == MOVE_DOWN);
    end
  end

  assign bus.target_floor = target;
  assign bus.pending      = pending;
  assign bus.door_open    = door_open_r;
  assign bus.dir_up       = dir_up_r;
  assign bus.dir_down     = dir_down_r;
  assign bus.busy         = (state != IDLE) | (|pending);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler; the bench plays the role
// of the floor FSM by driving present_floor directly.
module tb_elevator_request_scheduler;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  elevator_request_scheduler_if #(.N_FLOORS(4)) bus ();

  elevator_request_scheduler #(
    .N_FLOORS   (4),
    .DWELL_TICKS(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors            = 0;
    checks            = 0;
    reset             = 1'b1;
    bus.tick          = 1'b0;
    bus.call_req      = 4'b0000;
    bus.present_floor = 4'b0001;

    // T1: reset
    step();
    step();
    chk("t1_target", 32'(bus.target_floor), 32'h1);
    chk("t1_pending", 32'(bus.pending), 32'h0);
    chk("t1_door", 32'(bus.door_open), 32'h0);
    chk("t1_dir_up", 32'(bus.dir_up), 32'h0);
    chk("t1_dir_down", 32'(bus.dir_down), 32'h0);
    chk("t1_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;

    // T2: single call to top floor
    bus.call_req = 4'b1000;
    step();
    bus.call_req = 4'b0000;
    chk("t2_pending_t1", 32'(bus.pending), 32'h8);
    chk("t2_dir_up_t1", 32'(bus.dir_up), 32'h0);
    step();
    chk("t2_dir_up_t2", 32'(bus.dir_up), 32'h1);
    chk("t2_target_t2", 32'(bus.target_floor), 32'h8);
    chk("t2_busy", 32'(bus.busy), 32'h1);
    bus.present_floor = 4'b0010; step();
    bus.present_floor = 4'b0100; step();
    chk("t2_target_mid", 32'(bus.target_floor), 32'h8);
    bus.present_floor = 4'b1000; step();
    chk("t2_door", 32'(bus.door_open), 32'h1);
    chk("t2_dir_up_off", 32'(bus.dir_up), 32'h0);
    chk("t2_pending_clr", 32'(bus.pending), 32'h0);
    pulse_tick();
    step();
    pulse_tick();
    chk("t2_door_2ticks", 32'(bus.door_open), 32'h1);
    pulse_tick();
    chk("t2_door_closed", 32'(bus.door_open), 32'h0);
    chk("t2_idle_busy", 32'(bus.busy), 32'h0);
    chk("t2_idle_target", 32'(bus.target_floor), 32'h8);

    // T3: nearer call ahead picked up while moving up
    bus.present_floor = 4'b0001;
    step();
    chk("t3_idle_target", 32'(bus.target_floor), 32'h1);
    bus.call_req = 4'b1000; step();
    bus.call_req = 4'b0000; step();
    chk("t3_target_top", 32'(bus.target_floor), 32'h8);
    bus.present_floor = 4'b0010; step();
    bus.call_req = 4'b0100; step();
    bus.call_req = 4'b0000;
    chk("t3_target_still_top", 32'(bus.target_floor), 32'h8);
    step();
    chk("t3_target_near", 32'(bus.target_floor), 32'h4);
    chk("t3_dir_up", 32'(bus.dir_up), 32'h1);
    bus.present_floor = 4'b0100; step();
    chk("t3_door", 32'(bus.door_open), 32'h1);
    chk("t3_pending", 32'(bus.pending), 32'h8);
    chk("t3_target_door", 32'(bus.target_floor), 32'h4);

    // T4: ground call arrives during the dwell at 0100
    bus.call_req = 4'b0001; step();
    bus.call_req = 4'b0000;
    chk("t4_pending", 32'(bus.pending), 32'h9);
    pulse_tick();
    pulse_tick();
    chk("t4_door_held", 32'(bus.door_open), 32'h1);
    pulse_tick();
    chk("t4_dir_up", 32'(bus.dir_up), 32'h1);
    chk("t4_target_up", 32'(bus.target_floor), 32'h8);
    chk("t4_door_shut", 32'(bus.door_open), 32'h0);
    bus.present_floor = 4'b1000; step();
    chk("t4_door_top", 32'(bus.door_open), 32'h1);
    chk("t4_pending_top", 32'(bus.pending), 32'h1);
    pulse_tick();
    pulse_tick();
    pulse_tick();
    chk("t4_dir_down", 32'(bus.dir_down), 32'h1);
    chk("t4_target_down", 32'(bus.target_floor), 32'h1);
    bus.present_floor = 4'b0100; step();
    bus.present_floor = 4'b0010; step();
    chk("t4_target_ground", 32'(bus.target_floor), 32'h1);
    bus.present_floor = 4'b0001; step();
    chk("t4_door_ground", 32'(bus.door_open), 32'h1);
    chk("t4_pending_empty", 32'(bus.pending), 32'h0);
    pulse_tick();
    pulse_tick();
    pulse_tick();
    chk("t4_idle", 32'(bus.busy), 32'h0);

    // T5: call at the open floor restarts the dwell
    bus.call_req = 4'b0010; step();
    bus.call_req = 4'b0000; step();
    chk("t5_target", 32'(bus.target_floor), 32'h2);
    bus.present_floor = 4'b0010; step();
    chk("t5_door", 32'(bus.door_open), 32'h1);
    pulse_tick();
    pulse_tick();
    bus.call_req = 4'b0010; step();
    bus.call_req = 4'b0000;
    chk("t5_pending_masked", 32'(bus.pending), 32'h0);
    chk("t5_door_restart", 32'(bus.door_open), 32'h1);
    pulse_tick();
    pulse_tick();
    chk("t5_door_after_2", 32'(bus.door_open), 32'h1);
    pulse_tick();
    chk("t5_door_after_3", 32'(bus.door_open), 32'h0);
    chk("t5_busy", 32'(bus.busy), 32'h0);

    // T6: reset mid-travel, then invalid car positions
    bus.present_floor = 4'b0001; step();
    bus.call_req = 4'b1010; step();
    bus.call_req = 4'b0000; step();
    chk("t6_pending", 32'(bus.pending), 32'ha);
    chk("t6_target", 32'(bus.target_floor), 32'h2);
    chk("t6_dir_up", 32'(bus.dir_up), 32'h1);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("t6_rst_dir_up", 32'(bus.dir_up), 32'h0);
    chk("t6_rst_pending", 32'(bus.pending), 32'h0);
    chk("t6_rst_target", 32'(bus.target_floor), 32'h1);
    chk("t6_rst_busy", 32'(bus.busy), 32'h0);
    bus.call_req = 4'b0100; step();
    bus.call_req = 4'b0000; step();
    chk("t6_target_up", 32'(bus.target_floor), 32'h4);
    bus.present_floor = 4'b0110;
    bus.call_req      = 4'b0010; step();
    bus.call_req      = 4'b0000;
    chk("t6_inv_target", 32'(bus.target_floor), 32'h4);
    chk("t6_inv_dir_up", 32'(bus.dir_up), 32'h1);
    chk("t6_inv_pending", 32'(bus.pending), 32'h6);
    bus.present_floor = 4'b0000; step();
    chk("t6_zero_target", 32'(bus.target_floor), 32'h4);
    chk("t6_zero_pending", 32'(bus.pending), 32'h6);
    bus.present_floor = 4'b0010; step();
    chk("t6_door_mid", 32'(bus.door_open), 32'h1);
    chk("t6_pending_mid", 32'(bus.pending), 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
